// File: rtl/osu9t_rr_arbiter4.sv
// Four-requester round-robin arbiter with a registered, break-before-make grant.
// Optional hold-time limit with requester ban enabled by defining ARB_TIMEOUT_EN.
module osu9t_rr_arbiter4 #(
    parameter int N       = 4,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic         CLK,
    input  logic         RN,
    input  logic [N-1:0] REQ,
    output logic [N-1:0] GNT,
    output logic [1:0]   GNT_ID,
    output logic         BUSY,
    output logic         TMO
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // A misconfigured instance never grants rather than misbehaving silently.
    localparam bit CFG_OK = (N == 4) && (TIMEOUT >= 1) && (TIMEOUT <= 255) &&
                            ((64'd1 << CNT_W) > 64'(TIMEOUT));

    state_t      state_r, state_s;
    logic [3:0]  gnt_r, gnt_s;
    logic [1:0]  gnt_id_r, gnt_id_s;
    logic        busy_r, busy_s;
    logic [1:0]  ptr_r, ptr_s;
    logic [3:0]  ban_s;
    logic [3:0]  elig_s;
    logic [2:0]  pick_s;
    logic        tmo_s;

    // Returns {found, index} of the first eligible bit scanning up from ptr with wrap.
    function automatic logic [2:0] pick_f(input logic [3:0] elig, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (elig[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [3:0]       ban_r, ban_set_s;
    logic             tmo_r;

    assign ban_s = ban_r;
    assign TMO   = tmo_r;
`else
    assign ban_s = 4'b0000;
    assign TMO   = 1'b0;
`endif

    assign elig_s = CFG_OK ? (REQ & ~ban_s) : 4'b0000;
    assign pick_s = pick_f(elig_s, ptr_r);

    // Next-state and next-output decode.
    always_comb begin
        state_s   = state_r;
        gnt_s     = gnt_r;
        gnt_id_s  = gnt_id_r;
        busy_s    = busy_r;
        ptr_s     = ptr_r;
        tmo_s     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_s     = cnt_r;
        ban_set_s = 4'b0000;
`endif
        case (state_r)
            ST_IDLE, ST_RELEASE: begin
                // Idle and the dead cycle both arbitrate on the current request levels.
                if (pick_s[2]) begin
                    state_s  = ST_GRANT;
                    gnt_s    = 4'b0001 << pick_s[1:0];
                    gnt_id_s = pick_s[1:0];
                    busy_s   = 1'b1;
                    ptr_s    = pick_s[1:0] + 2'd1;
`ifdef ARB_TIMEOUT_EN
                    cnt_s    = {CNT_W{1'b0}};
`endif
                end else begin
                    state_s = ST_IDLE;
                    gnt_s   = 4'b0000;
                    busy_s  = 1'b0;
                end
            end
            ST_GRANT: begin
                if (!REQ[gnt_id_r]) begin
                    state_s = ST_RELEASE;
                    gnt_s   = 4'b0000;
                    busy_s  = 1'b0;
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    // Counter holds cycles already granted; this edge completes TIMEOUT.
                    state_s   = ST_RELEASE;
                    gnt_s     = 4'b0000;
                    busy_s    = 1'b0;
                    tmo_s     = 1'b1;
                    ban_set_s = 4'b0001 << gnt_id_r;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
`else
                end else begin
                    state_s = ST_GRANT;
                end
`endif
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = 4'b0000;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and registered output update.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_r  <= ST_IDLE;
            gnt_r    <= 4'b0000;
            gnt_id_r <= 2'd0;
            busy_r   <= 1'b0;
            ptr_r    <= 2'd0;
        end else begin
            state_r  <= state_s;
            gnt_r    <= gnt_s;
            gnt_id_r <= gnt_id_s;
            busy_r   <= busy_s;
            ptr_r    <= ptr_s;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter, timeout pulse and ban bits; a ban lifts once its request is seen low.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            cnt_r <= {CNT_W{1'b0}};
            ban_r <= 4'b0000;
            tmo_r <= 1'b0;
        end else begin
            cnt_r <= cnt_s;
            ban_r <= (ban_r & REQ) | ban_set_s;
            tmo_r <= tmo_s;
        end
    end
`else
    logic unused_s;
    assign unused_s = tmo_s;
`endif

    assign GNT    = gnt_r;
    assign GNT_ID = gnt_id_r;
    assign BUSY   = busy_r;

endmodule

// File: tb/tb_osu9t_rr_arbiter4.sv
// Self-checking bench for osu9t_rr_arbiter4: directed steps plus random requests
// checked against an owner/last-served reference model.
module tb_osu9t_rr_arbiter4;

    localparam int TLIM  = 4;
    localparam int STUCK = 1000;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RN;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic [1:0] GNT_ID;
    logic       BUSY;
    logic       TMO;

    osu9t_rr_arbiter4 #(.N(4), .TIMEOUT(TLIM), .CNT_W(8)) dut (
        .CLK(CLK), .RN(RN), .REQ(REQ), .GNT(GNT),
        .GNT_ID(GNT_ID), .BUSY(BUSY), .TMO(TMO)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: who owns the resource, who was served last, how long held.
    int owner;
    int last_served;
    int shown_id;
    int held;
    bit banned [4];
    bit exp_tmo;

    task automatic model_reset();
        owner       = -1;
        last_served = 3;
        shown_id    = 0;
        held        = 0;
        exp_tmo     = 1'b0;
        for (int i = 0; i < 4; i++) banned[i] = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r);
        bit nb [4];
        exp_tmo = 1'b0;
        for (int i = 0; i < 4; i++) nb[i] = banned[i] && r[i];
        if (owner >= 0) begin
            if (!r[owner]) begin
                owner = -1;
            end else if (TMO_ON && held == TLIM) begin
                nb[owner] = 1'b1;
                exp_tmo   = 1'b1;
                owner     = -1;
            end else begin
                held++;
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (last_served + k) % 4;
                if (owner < 0 && r[c] && !banned[c]) begin
                    owner       = c;
                    last_served = c;
                    shown_id    = c;
                    held        = 1;
                end
            end
        end
        for (int i = 0; i < 4; i++) banned[i] = nb[i];
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %b, want %b", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [3:0] eg;
        eg = (owner >= 0) ? 4'(1 << owner) : 4'b0000;
        chk("gnt", GNT, eg);
        chk("gnt_id", {2'b00, GNT_ID}, 4'(shown_id));
        chk("busy", {3'b000, BUSY}, {3'b000, owner >= 0});
        chk("tmo", {3'b000, TMO}, {3'b000, exp_tmo});
    endtask

    task automatic cycle(input logic [3:0] r);
        REQ = r;
        @(posedge CLK);
        model_step(r);
        #1;
        check_model();
    endtask

    task automatic do_reset(input logic [3:0] r);
        RN  = 1'b0;
        REQ = r;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_model();
        RN = 1'b1;
    endtask

    initial begin
        int         ord [5];
        int         id;
        logic [3:0] rq;
        ord = '{0, 1, 2, 3, 0};

        // Reset with all requesting, first grant, release, next owner
        do_reset(4'b1111);
        chk("rst_gnt", GNT, 4'b0000);
        cycle(4'b1111);
        chk("first_gnt", GNT, 4'b0001);
        cycle(4'b1110);
        chk("release_gap", GNT, 4'b0000);
        cycle(4'b1110);
        chk("second_gnt", GNT, 4'b0010);

        // Rotation 0,1,2,3,0 with one dead cycle between owners
        do_reset(4'b1111);
        cycle(4'b1111);
        for (int t = 0; t < 5; t++) begin
            chk("order", {2'b00, GNT_ID}, 4'(ord[t]));
            id = owner;
            cycle(4'b1111);
            cycle(4'b1111);
            cycle(4'b1111 & ~(4'b0001 << id));
            chk("rot_gap", GNT, 4'b0000);
            cycle(4'b1111);
        end

        // Lone requester 3, then wrap-around to 0
        cycle(4'b0000);
        cycle(4'b0000);
        cycle(4'b1000);
        chk("only3", GNT, 4'b1000);
        cycle(4'b0000);
        cycle(4'b1001);
        chk("wrap0", GNT, 4'b0001);

        // Asynchronous reset mid-grant
        cycle(4'b0000);
        cycle(4'b0100);
        chk("pre_rst", GNT, 4'b0100);
        #3;
        RN = 1'b0;
        #1;
        chk("async_gnt", GNT, 4'b0000);
        chk("async_busy", {3'b000, BUSY}, 4'b0000);
        model_reset();
        check_model();
        @(posedge CLK);
        #1;
        RN = 1'b1;
        cycle(4'b0100);
        chk("post_rst", GNT, 4'b0100);

        // Stuck requester 1 with requester 2 waiting
        do_reset(4'b0000);
        for (int c = 0; c < STUCK; c++) begin
            cycle(4'b0110);
            if (c == 4) begin
                chk("stuck_e5_gnt", GNT, TMO_ON ? 4'b0000 : 4'b0010);
                chk("stuck_e5_tmo", {3'b000, TMO}, {3'b000, TMO_ON});
            end
            if (c == 5) chk("stuck_e6_gnt", GNT, TMO_ON ? 4'b0100 : 4'b0010);
        end
        cycle(4'b0100);
        cycle(4'b0110);
        cycle(4'b0110);
        cycle(4'b0000);

        // Random request levels with long holds
        rq = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 4) == 0) rq[b] = ~rq[b];
            end
            cycle(rq);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/osu9t_rr_arbiter4.md
# osu9t_rr_arbiter4

Four-requester round-robin arbiter with a registered, break-before-make grant handshake, used to share one cell-level resource among four clients, such as a shared OAI21/AOI-based compare/enable path or a shared calibration driver. It sits between the requesting digital controllers and the shared resource's enable inputs. It guarantees at most one one-hot grant at any time, a dead cycle between owners, and fair rotation.

## Interface
- N, 4, number of requesters; only 4 is supported.
- TIMEOUT, 15, maximum cycles a single grant may be held; legal range 1..255. Used only when ARB_TIMEOUT_EN is defined.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > TIMEOUT.
- CLK  input  1  single clock; all state updates on the rising edge.
- RN  input  1  asynchronous active-low reset.
- REQ  input  4  level requests, one per client; a client holds its bit high for the whole transaction.
- GNT  output  4  registered one-hot grant; all zero when no owner.
- GNT_ID  output  2  binary index of the current owner; holds the last owner when GNT=0.
- BUSY  output  1  registered; high while in GRANT.
- TMO  output  1  one-cycle pulse on forced release; tied 0 when the macro is absent.

## Operation
- State: a 2-bit FSM with states IDLE, GRANT, RELEASE.
- PTR: a 2-bit rotating priority pointer.
- Arbitration: the winner is the first set bit of REQ & ~BAN, scanning from PTR upward and wrapping 3→0.
- IDLE:
  - If any eligible REQ is present, go to GRANT and load GNT, GNT_ID and BUSY=1 at the same edge.
  - Set PTR = (winner+1) mod 4.
  - Otherwise remain in IDLE.
- GRANT:
  - Hold the grant while REQ[GNT_ID]=1. Other requests are ignored; there is no preemption.
  - When REQ[GNT_ID]=0 is sampled, clear GNT and BUSY and go to RELEASE.
- RELEASE:
  - Exactly one cycle with GNT=0.
  - Arbitration is evaluated at the exiting edge, so the next owner's GNT appears one edge after release.
  - If there is no eligible REQ, go to IDLE.
- Fairness: a requester that has just been served is lowest priority in the next arbitration. Worst-case wait is 3 full transactions.
- Reset (RN=0), asynchronous and immediate:
  - State=IDLE, GNT=0, GNT_ID=0, BUSY=0, TMO=0, PTR=0, counter=0, BAN=0.
  - Reset mid-grant drops GNT immediately with no RELEASE cycle.
- REQ bits asserted while not eligible are simply left pending. No request is lost or latched; the decision always uses the current level.

## Timing
- Request to grant latency is 1 edge from IDLE: REQ high before edge k gives GNT high after edge k.
- Release to next grant takes 2 edges: REQ drop sampled at edge k gives GNT=0 after k, then new GNT after k+1.
- Simultaneous drop of the owner's REQ and rise of another REQ:
  - RELEASE still occurs.
  - The new request competes at the RELEASE exit edge.
- A same-cycle drop and re-raise of the owner's REQ is treated as a drop. The owner re-arbitrates with lowest priority.
- All outputs are registered. There is no combinational path from REQ to any output.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter clears on GRANT entry and increments each GRANT cycle.
  - When it reaches TIMEOUT with REQ[GNT_ID] still high, the grant is forced off and the FSM goes to RELEASE.
  - TMO pulses high for exactly that one cycle.
  - BAN[GNT_ID] is set. A banned bit clears when its REQ is sampled low.
- ARB_TIMEOUT_EN undefined:
  - No counter and no BAN register (BAN is constant 0).
  - TMO=0; a grant is held indefinitely.

## Test plan
- Reset with REQ=4'b1111, then release RN → after edge 1 GNT=0001, GNT_ID=0, BUSY=1. Drop REQ[0] → RELEASE with GNT=0 for one cycle, then GNT=0010.
- REQ=4'b1111 held, each owner drops and re-raises after 3 cycles → grant order 0,1,2,3,0, with exactly one GNT=0 cycle between owners.
- REQ=4'b1000 only, from IDLE → GNT=1000 after 1 edge, PTR=0. Then REQ=4'b1001 after release → GNT=0001 (wrap-around).
- Assert RN=0 mid-grant with GNT=0100 → GNT=0, BUSY=0 immediately, without waiting for a clock. After release, REQ=0100 → GNT=0100 (PTR reset to 0).
- With ARB_TIMEOUT_EN and TIMEOUT=4, REQ[1] stuck high and REQ[2] high:
  - GNT=0010 drops after 4 GRANT cycles, with TMO pulsing 1 cycle.
  - GNT=0100 follows.
  - Client 1 is not re-granted until REQ[1] has been seen low.
- Without ARB_TIMEOUT_EN, same stimulus held for 1000 cycles → GNT=0010 holds throughout and TMO stays 0.
